// File: rtl/port_arbiter_pkg.sv
// rtl/port_arbiter_pkg.sv - shared router constants, port indices and arbiter state encoding
package port_arbiter_pkg;

   localparam int PORTS = 5;
   localparam int SEL_W = 3;

   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_E = 2;
   localparam int PORT_S = 3;
   localparam int PORT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACK    = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// rtl/port_arbiter_rr_pick.sv - combinational rotating-priority encoder
module rr_pick #(
   parameter int PORTS = 5,
   parameter int SEL_W = 3
) (
   input  logic [PORTS-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [PORTS-1:0] win,
   output logic [SEL_W-1:0] win_idx,
   output logic             any
);

   logic found;
   int   idx;

   // Scan upward from ptr; the wrap is an explicit compare so PORTS need not be a power of two.
   always_comb begin
      win     = '0;
      win_idx = '0;
      any     = |req;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= PORTS) idx = idx - PORTS;
         if (!found && req[idx]) begin
            found      = 1'b1;
            win[idx]   = 1'b1;
            win_idx    = SEL_W'(idx);
         end
      end
   end

endmodule

// File: rtl/port_arbiter.sv
// rtl/port_arbiter.sv - per-output-port round-robin arbiter with packet lock
module port_arbiter #(
   parameter int PORTS = port_arbiter_pkg::PORTS,
   parameter int SEL_W = port_arbiter_pkg::SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] rqs_in,
   input  logic             credit_ok,
   input  logic             tail_done,
   output logic [PORTS-1:0] arb_ack,
   output logic [PORTS-1:0] grant,
   output logic [SEL_W-1:0] xbar_sel,
   output logic             busy
);

   import port_arbiter_pkg::*;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr, ptr_d;
   logic [PORTS-1:0] grant_d, ack_d;
   logic [SEL_W-1:0] sel_d;
   logic             busy_d;

   logic [PORTS-1:0] pick_win;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;

   rr_pick #(
      .PORTS (PORTS),
      .SEL_W (SEL_W)
   ) u_pick (
      .req     (rqs_in),
      .ptr     (ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr;
      grant_d = grant;
      ack_d   = '0;
      sel_d   = xbar_sel;
      busy_d  = busy;
      case (state_q)
         ST_IDLE: begin
            if (pick_any && credit_ok) begin
               state_d = ST_ACK;
               grant_d = pick_win;
               ack_d   = pick_win;
               sel_d   = pick_idx;
               busy_d  = 1'b1;
               ptr_d   = (pick_idx == SEL_W'(PORTS - 1)) ? '0 : pick_idx + SEL_W'(1);
            end
         end
         ST_ACK, ST_LOCKED: begin
            // Requests and credit are deliberately ignored until the tail crosses.
            if (tail_done) begin
               state_d = ST_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         ptr      <= '0;
         grant    <= '0;
         arb_ack  <= '0;
         xbar_sel <= '0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr      <= ptr_d;
         grant    <= grant_d;
         arb_ack  <= ack_d;
         xbar_sel <= sel_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_port_arbiter.sv
// tb/tb_port_arbiter.sv - self-checking bench for port_arbiter
module tb_port_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] rqs_in = '0;
   logic       credit_ok = 1'b0;
   logic       tail_done = 1'b0;
   logic [4:0] arb_ack;
   logic [4:0] grant;
   logic [2:0] xbar_sel;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int mptr     = 0;

   port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rqs_in    (rqs_in),
      .credit_ok (credit_ok),
      .tail_done (tail_done),
      .arb_ack   (arb_ack),
      .grant     (grant),
      .xbar_sel  (xbar_sel),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [4:0] r, input int p);
      for (int k = 0; k < 5; k++) begin
         if (r[(p + k) % 5]) return (p + k) % 5;
      end
      return -1;
   endfunction

   function automatic logic [4:0] onehot(input int w);
      logic [4:0] v;
      v = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      rqs_in = '0;
      credit_ok = 1'b0;
      tail_done = 1'b0;
      step();
      rst = 1'b1;
      mptr = 0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      n_checks++;
      if ({arb_ack, grant, xbar_sel, busy} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", {arb_ack, grant, xbar_sel, busy});
      end
      n_checks++;
      if (dut.ptr !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_ptr: got %0d required 0", dut.ptr);
      end
      do_reset();
   endtask

   task automatic test_single_request();
      int w;
      rqs_in = 5'b00100;
      credit_ok = 1'b1;
      w = model_pick(rqs_in, mptr);
      mptr = (w + 1) % 5;
      step();
      n_checks++;
      if ({arb_ack, grant, xbar_sel, busy} !== {5'b00100, 5'b00100, 3'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL single_ack: got ack=%b grant=%b sel=%0d busy=%b required ack=00100 grant=00100 sel=2 busy=1",
                  arb_ack, grant, xbar_sel, busy);
      end
      n_checks++;
      if (dut.ptr !== 3'(mptr)) begin
         n_fail++;
         $display("FAIL single_ptr: got %0d required %0d", dut.ptr, mptr);
      end
      rqs_in = '0;
      step();
      n_checks++;
      if ({arb_ack, grant, busy} !== {5'b00000, 5'b00100, 1'b1}) begin
         n_fail++;
         $display("FAIL single_locked: got ack=%b grant=%b busy=%b required ack=0 grant=00100 busy=1",
                  arb_ack, grant, busy);
      end
      tail_done = 1'b1;
      step();
      tail_done = 1'b0;
      n_checks++;
      if ({grant, busy, xbar_sel} !== {5'b00000, 1'b0, 3'd2}) begin
         n_fail++;
         $display("FAIL single_release: got grant=%b busy=%b sel=%0d required grant=0 busy=0 sel=2",
                  grant, busy, xbar_sel);
      end
   endtask

   task automatic test_round_robin();
      int exp_w;
      do_reset();
      rqs_in = 5'b11111;
      credit_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_w = i % 5;
         step();
         n_checks++;
         if ({arb_ack, grant, xbar_sel} !== {onehot(exp_w), onehot(exp_w), 3'(exp_w)}) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: got ack=%b sel=%0d required winner %0d", i, arb_ack, xbar_sel, exp_w);
         end
         if (exp_w == 4) begin
            n_checks++;
            if (dut.ptr !== 3'd0) begin
               n_fail++;
               $display("FAIL rr_ptr_wrap: got %0d required 0", dut.ptr);
            end
         end
         tail_done = 1'b1;
         step();
         tail_done = 1'b0;
         n_checks++;
         if ({arb_ack, grant, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL rr_gap[%0d]: got ack=%b grant=%b busy=%b required all 0", i, arb_ack, grant, busy);
         end
      end
      mptr = 1;
      rqs_in = '0;
   endtask

   task automatic test_lock_hold();
      int w;
      rqs_in = 5'b10000;
      credit_ok = 1'b1;
      w = model_pick(rqs_in, mptr);
      mptr = (w + 1) % 5;
      step();
      n_checks++;
      if (arb_ack !== 5'b10000) begin
         n_fail++;
         $display("FAIL lock_first_ack: got %b required 10000", arb_ack);
      end
      rqs_in = 5'b01000;
      credit_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({arb_ack, grant, xbar_sel, busy} !== {5'b00000, 5'b10000, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL lock_hold[%0d]: got ack=%b grant=%b sel=%0d busy=%b required ack=0 grant=10000 sel=4 busy=1",
                     i, arb_ack, grant, xbar_sel, busy);
         end
      end
      credit_ok = 1'b1;
      tail_done = 1'b1;
      step();
      tail_done = 1'b0;
      n_checks++;
      if ({grant, busy} !== 6'd0) begin
         n_fail++;
         $display("FAIL lock_release: got grant=%b busy=%b required 0", grant, busy);
      end
      w = model_pick(rqs_in, mptr);
      mptr = (w + 1) % 5;
      step();
      n_checks++;
      if (arb_ack !== onehot(w)) begin
         n_fail++;
         $display("FAIL lock_next_ack: got %b required %b", arb_ack, onehot(w));
      end
      rqs_in = '0;
      tail_done = 1'b1;
      step();
      tail_done = 1'b0;
   endtask

   task automatic test_credit_gating();
      int w;
      rqs_in = 5'b00010;
      credit_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({arb_ack, busy} !== 6'd0) begin
            n_fail++;
            $display("FAIL credit_blocked[%0d]: got ack=%b busy=%b required 0", i, arb_ack, busy);
         end
      end
      credit_ok = 1'b1;
      w = model_pick(rqs_in, mptr);
      mptr = (w + 1) % 5;
      step();
      n_checks++;
      if (arb_ack !== 5'b00010) begin
         n_fail++;
         $display("FAIL credit_ack: got %b required 00010", arb_ack);
      end
      rqs_in = '0;
      tail_done = 1'b1;
      step();
      tail_done = 1'b0;
   endtask

   task automatic test_single_flit();
      int w;
      rqs_in = 5'b01001;
      credit_ok = 1'b1;
      w = model_pick(rqs_in, mptr);
      mptr = (w + 1) % 5;
      step();
      rqs_in = rqs_in & ~onehot(w);
      tail_done = 1'b1;
      n_checks++;
      if ({grant, busy} !== {onehot(w), 1'b1}) begin
         n_fail++;
         $display("FAIL flit_grant: got grant=%b busy=%b required %b/1", grant, busy, onehot(w));
      end
      step();
      tail_done = 1'b0;
      n_checks++;
      if ({arb_ack, grant, busy, xbar_sel} !== {10'd0, 1'b0, 3'(w)}) begin
         n_fail++;
         $display("FAIL flit_release: got ack=%b grant=%b busy=%b sel=%0d required 0/0/0/%0d",
                  arb_ack, grant, busy, xbar_sel, w);
      end
      w = model_pick(rqs_in, mptr);
      mptr = (w + 1) % 5;
      step();
      n_checks++;
      if (arb_ack !== onehot(w)) begin
         n_fail++;
         $display("FAIL flit_back_to_back: got %b required %b", arb_ack, onehot(w));
      end
      rqs_in = '0;
      tail_done = 1'b1;
      step();
      tail_done = 1'b0;
   endtask

   task automatic test_mid_reset();
      rqs_in = 5'b10000;
      credit_ok = 1'b1;
      step();
      rqs_in = '0;
      step();
      n_checks++;
      if (grant !== 5'b10000) begin
         n_fail++;
         $display("FAIL midrst_locked: got %b required 10000", grant);
      end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({arb_ack, grant, xbar_sel, busy} !== 14'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got %h required 0", {arb_ack, grant, xbar_sel, busy});
      end
      rqs_in = 5'b10001;
      credit_ok = 1'b1;
      step();
      rst = 1'b1;
      mptr = 0;
      step();
      n_checks++;
      if (arb_ack !== 5'b00001) begin
         n_fail++;
         $display("FAIL midrst_restart: got %b required 00001", arb_ack);
      end
      mptr = 1;
      rqs_in = '0;
      tail_done = 1'b1;
      step();
      tail_done = 1'b0;
   endtask

   task automatic test_random();
      int         w, d, len;
      logic [4:0] r;
      for (int p = 0; p < 40; p++) begin
         r = 5'($urandom_range(1, 31));
         rqs_in = r;
         credit_ok = 1'b0;
         d = $urandom_range(0, 2);
         for (int i = 0; i < d; i++) begin
            step();
            n_checks++;
            if ({arb_ack, busy} !== 6'd0) begin
               n_fail++;
               $display("FAIL rand_nocredit[%0d]: got ack=%b busy=%b required 0", p, arb_ack, busy);
            end
         end
         credit_ok = 1'b1;
         w = model_pick(r, mptr);
         mptr = (w + 1) % 5;
         step();
         n_checks++;
         if ({arb_ack, grant, xbar_sel, busy} !== {onehot(w), onehot(w), 3'(w), 1'b1}) begin
            n_fail++;
            $display("FAIL rand_ack[%0d]: rqs=%b got ack=%b grant=%b sel=%0d required winner %0d",
                     p, r, arb_ack, grant, xbar_sel, w);
         end
         len = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            rqs_in = 5'($urandom);
            credit_ok = 1'($urandom);
            step();
            n_checks++;
            if ({arb_ack, grant, busy} !== {5'b00000, onehot(w), 1'b1}) begin
               n_fail++;
               $display("FAIL rand_hold[%0d]: got ack=%b grant=%b busy=%b required 0/%b/1",
                        p, arb_ack, grant, busy, onehot(w));
            end
         end
         tail_done = 1'b1;
         step();
         tail_done = 1'b0;
         n_checks++;
         if ({grant, busy, xbar_sel} !== {6'd0, 3'(w)}) begin
            n_fail++;
            $display("FAIL rand_release[%0d]: got grant=%b busy=%b sel=%0d required 0/0/%0d",
                     p, grant, busy, xbar_sel, w);
         end
      end
      rqs_in = '0;
   endtask

   initial begin
      test_reset();
      test_single_request();
      test_round_robin();
      test_lock_hold();
      test_credit_gating();
      test_single_flit();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
